// File: rtl/retire_rat.sv
// Retirement register alias table: committed arch->phys map, frees superseded
// physical registers on retire, and re-seeds the rename free list by scanning.
module retire_rat (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             FLUSH,
  input  logic             commit_valid,
  input  logic             commit_regwr_flag,
  input  logic [4:0]       commit_arch_reg,
  input  logic [5:0]       commit_phys_reg,
  output logic             commit_ready,
  output logic             rrat_free,
  output logic [5:0]       rrat_free_reg,
  output logic [31:0][5:0] rrat_map,
  output logic             rrat_scanning
);

  typedef enum logic {SCAN, RUN} state_t;

  state_t            state;
  logic [31:0][5:0]  map;
  logic [63:0]       mapped;
  logic [5:0]        scan_ptr;
  logic [5:0]        old_phys;
  logic              accept;
  logic              do_write;

  assign commit_ready = (state == RUN) && !STALL;
  assign accept       = commit_ready && commit_valid;
  assign old_phys     = map[commit_arch_reg];
  // r0 is pinned to p0, and re-committing the current mapping frees nothing
  assign do_write     = accept && commit_regwr_flag && (commit_arch_reg != 5'd0) &&
                        (commit_phys_reg != old_phys);
  assign rrat_map     = map;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 32; i++) map[i] <= 6'(i);
      mapped        <= {32'h0000_0000, 32'hFFFF_FFFF};
      state         <= SCAN;
      scan_ptr      <= 6'd1;
      rrat_free     <= 1'b0;
      rrat_free_reg <= 6'd0;
      rrat_scanning <= 1'b1;
    end else begin
      rrat_free <= 1'b0;
      if (do_write) begin
        map[commit_arch_reg]    <= commit_phys_reg;
        mapped[old_phys]        <= 1'b0;
        mapped[commit_phys_reg] <= 1'b1;
      end
      // A commit on the flush edge still updates the map; the scan recovers its old register
      if (FLUSH) begin
        state         <= SCAN;
        scan_ptr      <= 6'd1;
        rrat_scanning <= 1'b1;
      end else begin
        case (state)
          SCAN: begin
            if (!STALL) begin
              if (!mapped[scan_ptr]) begin
                rrat_free     <= 1'b1;
                rrat_free_reg <= scan_ptr;
              end
              scan_ptr <= scan_ptr + 6'd1;
              if (scan_ptr == 6'd63) begin
                state         <= RUN;
                rrat_scanning <= 1'b0;
              end
            end
          end
          RUN: begin
            if (do_write) begin
              rrat_free     <= 1'b1;
              rrat_free_reg <= old_phys;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule
